// File: rtl/ahb_lite_stream_loader.sv
// AHB-Lite single-master write engine: packs a byte stream little-endian into
// bus words and writes them as single NONSEQ transfers to consecutive addresses.
module ahb_lite_stream_loader #(
  parameter int HADDR_WIDTH = 17,
  parameter int HDATA_WIDTH = 64,
  parameter int LEN_WIDTH   = 14
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   start,
  input  logic [HADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]   len_words,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [HADDR_WIDTH-1:0] HADDR,
  output logic [1:0]             HTRANS,
  output logic [2:0]             HSIZE,
  output logic                   HWRITE,
  output logic [HDATA_WIDTH-1:0] HWDATA,
  input  logic                   HREADY,
  input  logic                   HRESP,
  output logic [2:0]             dbg_state
);
  localparam int NB = HDATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (LB > 0) ? LB : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_ERR    = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [HADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   idx_q, idx_d;
  logic [LEN_WIDTH-1:0]   packed_q, packed_d;
  logic [HDATA_WIDTH-1:0] pack_q, pack_d;
  logic [CW-1:0]          pack_cnt_q, pack_cnt_d;
  logic                   pack_full_q, pack_full_d;
  logic [HDATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   wr_valid_q, wr_valid_d;
  logic                   err_q, err_d;

  logic start_acc, data_ok, wr_free, byte_acc;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    packed_d    = packed_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    pack_full_d = pack_full_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = wr_valid_q;
    err_d       = err_q;

    busy      = state_q inside {ST_WAIT, ST_ADDR, ST_DATA, ST_ERR};
    done      = (state_q == ST_FINISH);
    start_acc = start && (state_q == ST_IDLE || state_q == ST_FINISH);
    data_ok   = (state_q == ST_DATA) && HREADY && !HRESP;
    wr_free   = !wr_valid_q || data_ok;
    // A full pack register frees up in the same cycle it hands over, so the
    // stream only stalls when both buffers are occupied.
    s_ready   = (state_q inside {ST_WAIT, ST_ADDR, ST_DATA}) &&
                !((state_q == ST_DATA) && HRESP) &&
                (packed_q < len_q) && (!pack_full_q || wr_free);
    byte_acc  = s_valid && s_ready;

    if (data_ok) wr_valid_d = 1'b0;
    if (pack_full_q && wr_free) begin
      wr_data_d   = pack_q;
      wr_valid_d  = 1'b1;
      pack_full_d = 1'b0;
    end
    if (byte_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (pack_cnt_q == CW'(k)) pack_d[8*k +: 8] = s_data;
      end
      if (pack_cnt_q == CW'(NB-1)) begin
        pack_cnt_d  = '0;
        pack_full_d = 1'b1;
        packed_d    = packed_q + LEN_WIDTH'(1);
      end else begin
        pack_cnt_d = pack_cnt_q + CW'(1);
      end
    end

    case (state_q)
      ST_WAIT: if (wr_valid_q) state_d = ST_ADDR;
      ST_ADDR: if (HREADY) state_d = ST_DATA;
      ST_DATA: begin
        if (HRESP) begin
          err_d   = 1'b1;
          state_d = HREADY ? ST_FINISH : ST_ERR;
        end else if (HREADY) begin
          idx_d = idx_q + LEN_WIDTH'(1);
          if (idx_d == len_q)   state_d = ST_FINISH;
          else if (pack_full_q) state_d = ST_ADDR;
          else                  state_d = ST_WAIT;
        end
      end
      ST_ERR: if (HREADY) state_d = ST_FINISH;
      ST_FINISH: begin
        state_d     = ST_IDLE;
        pack_cnt_d  = '0;
        pack_full_d = 1'b0;
        wr_valid_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_acc) begin
      base_d      = base_addr & ~(HADDR_WIDTH'(NB-1));
      len_d       = len_words;
      idx_d       = '0;
      packed_d    = '0;
      pack_cnt_d  = '0;
      pack_full_d = 1'b0;
      wr_valid_d  = 1'b0;
      err_d       = 1'b0;
      state_d     = (len_words == '0) ? ST_FINISH : ST_WAIT;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      packed_q    <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      pack_full_q <= 1'b0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      packed_q    <= packed_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_full_q <= pack_full_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      err_q       <= err_d;
    end
  end

  assign HADDR     = base_q + (HADDR_WIDTH'(idx_q) << LB);
  assign HTRANS    = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
  assign HWRITE    = (state_q == ST_ADDR);
  assign HSIZE     = 3'(LB);
  assign HWDATA    = wr_data_q;
  assign err       = err_q;
  assign dbg_state = state_q;
endmodule
